// File: rtl/tlul_pkg.sv
// TL-UL bus parameters and channel bundles.
// Shared by every TileLink-UL block on this crossbar.
package top_pkg;
  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_SZW = 2;
endpackage

package tlul_pkg;
  import top_pkg::*;

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;
endpackage

// File: rtl/tlul_host_arb.sv
// M:1 TL-UL host arbiter: round-robin with grant lock,
// outstanding limit, and source-tagged response routing.
module tlul_host_arb
  import tlul_pkg::*;
#(
  parameter int M      = 4,
  parameter int MaxOut = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  tl_h2d_t [M-1:0] tl_h_i,
  output tl_d2h_t [M-1:0] tl_h_o,
  output tl_h2d_t         tl_d_o,
  input  tl_d2h_t         tl_d_i
);
  localparam int IDW = $clog2(M);
  localparam int CW  = $clog2(MaxOut + 1);
  localparam int AIW = top_pkg::TL_AIW;

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] lock_idx_q, lock_idx_d;
  logic           lock_q, lock_d;
  logic [CW-1:0]  out_cnt_q, out_cnt_d;

  logic [IDW-1:0] gnt_idx, rsp_idx;
  logic           gnt_vld, full, rsp_ok;
  logic           a_acc, d_acc;
  tl_h2d_t        gnt_req;

  // Pick the granted host: locked host, else first requester from rr_ptr.
  always_comb begin
    logic [IDW-1:0] cand;
    cand    = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (lock_q) begin
      gnt_vld = 1'b1;
      gnt_idx = lock_idx_q;
    end else begin
      for (int k = M - 1; k >= 0; k--) begin
        cand = IDW'((int'(rr_ptr_q) + k) % M);
        if (tl_h_i[cand].a_valid) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  assign full    = (out_cnt_q == CW'(MaxOut));
  assign rsp_idx = tl_d_i.d_source[IDW-1:0];
  assign rsp_ok  = int'(rsp_idx) < M;

  // Request mux, ready fan-out and response demux.
  always_comb begin
    gnt_req         = tl_h_i[gnt_idx];
    gnt_req.d_ready = 1'b0;
    tl_d_o          = gnt_req;
    tl_d_o.a_valid  = gnt_vld & gnt_req.a_valid & ~full;
    tl_d_o.a_source = {gnt_req.a_source[AIW-1-IDW:0], gnt_idx};
    tl_d_o.d_ready  = rsp_ok ? tl_h_i[rsp_idx].d_ready : 1'b1;
    for (int i = 0; i < M; i++) begin
      tl_h_o[i]          = tl_d_i;
      tl_h_o[i].d_source = tl_d_i.d_source >> IDW;
      tl_h_o[i].d_valid  = tl_d_i.d_valid & (rsp_idx == IDW'(i));
      tl_h_o[i].a_ready  = gnt_vld & (gnt_idx == IDW'(i))
                         & tl_d_i.a_ready & ~full;
    end
  end

  assign a_acc = tl_d_o.a_valid & tl_d_i.a_ready;
  assign d_acc = tl_d_i.d_valid & tl_d_o.d_ready;

  // Lock on a stalled offer, rotate on accept, track outstanding.
  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    out_cnt_d  = out_cnt_q;
    if (a_acc) begin
      lock_d   = 1'b0;
      rr_ptr_d = IDW'((int'(gnt_idx) + 1) % M);
    end else if (tl_d_o.a_valid) begin
      lock_d     = 1'b1;
      lock_idx_d = gnt_idx;
    end
    if (a_acc && !d_acc) begin
      out_cnt_d = out_cnt_q + CW'(1);
    end else if (!a_acc && d_acc) begin
      out_cnt_d = out_cnt_q - CW'(1);
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      out_cnt_q  <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      out_cnt_q  <= out_cnt_d;
    end
  end

  a_no_ovf: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (a_acc && !d_acc) |-> out_cnt_q != CW'(MaxOut));
  a_no_unf: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (d_acc && !a_acc) |-> out_cnt_q != '0);
  a_rsp_rng: assert property (@(posedge clk_i) disable iff (!rst_ni)
    tl_d_i.d_valid |-> rsp_ok);
  a_lock_stb: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> gnt_req.a_valid && gnt_req == $past(gnt_req));

  for (genvar g = 0; g < M; g++) begin : g_src_chk
    a_src_hi: assert property (@(posedge clk_i) disable iff (!rst_ni)
      tl_h_i[g].a_valid |-> tl_h_i[g].a_source[AIW-1 -: IDW] == '0);
  end
endmodule
